// File: rtl/typedef_pkg.sv
`default_nettype none
// ============================================================================
// Module      : typedef_pkg
// Description : Shared types and constants for the post-retire store buffer:
//               buffer entry layout, drain FSM states, store funct3 encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package typedef_pkg;

  localparam int SB_ADDR_WIDTH = 32;
  localparam int SB_DATA_WIDTH = 32;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // One queued store, already formatted as a word-aligned write
  typedef struct packed {
    logic [SB_ADDR_WIDTH-1:0] addr;
    logic [SB_DATA_WIDTH-1:0] data;
    logic [3:0]               strb;
  } SB_ENTRY_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } sb_state_t;

endpackage
`default_nettype wire

// File: rtl/sb_store_align.sv
`default_nettype none
// ============================================================================
// Module      : sb_store_align
// Description : Converts a byte address, funct3 and unaligned store data into
//               a word address, lane-replicated data and byte strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_store_align
  import typedef_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [2:0]            funct3,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [3:0]            strb
);

  assign waddr = {addr[ADDR_WIDTH-1:2], 2'b00};

  // Replicate the significant bytes into every lane; strobes pick the lanes.
  // Unknown funct3 still produces an entry, just one that writes no bytes.
  always_comb begin
    wdata = data;
    strb  = 4'b0000;
    case (funct3)
      F3_SB: begin
        wdata = {4{data[7:0]}};
        strb  = 4'b0001 << addr[1:0];
      end
      F3_SH: begin
        wdata = {2{data[15:0]}};
        strb  = 4'b0011 << {addr[1], 1'b0};
      end
      F3_SW: begin
        strb  = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/store_commit_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_commit_buffer
// Description : In-order post-retire store queue. Formats stores at enqueue,
//               drains them one per ack over a req/ack write port, and flags
//               loads whose word address aliases a pending store.
// Revision    : 1.0 - initial release
// ============================================================================
module store_commit_buffer
  import typedef_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       retire_store_valid,
  input  logic [ADDR_WIDTH-1:0]      retire_store_addr,
  input  logic [DATA_WIDTH-1:0]      retire_store_data,
  input  logic [2:0]                 retire_store_funct3,
  output logic                       sb_full,
  output logic                       sb_empty,
  output logic [$clog2(DEPTH):0]     sb_count,
  output logic                       mem_wr_req,
  output logic [ADDR_WIDTH-1:0]      mem_wr_addr,
  output logic [DATA_WIDTH-1:0]      mem_wr_data,
  output logic [3:0]                 mem_wr_strb,
  input  logic                       mem_wr_ack,
  input  logic [ADDR_WIDTH-1:0]      ld_check_addr,
  output logic                       ld_conflict
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  SB_ENTRY_t             entries [DEPTH];
  logic      [PW-1:0]    head;
  logic      [PW-1:0]    tail;
  logic      [PW-1:0]    count;
  sb_state_t             state;
  sb_state_t             state_next;
  logic                  enq;
  logic                  deq;
  logic                  load_out;
  logic      [IW-1:0]    load_idx;
  logic [ADDR_WIDTH-1:0] fmt_addr;
  logic [DATA_WIDTH-1:0] fmt_data;
  logic      [3:0]       fmt_strb;
  logic      [DEPTH-1:0] hit;

  // Committed stores are architectural, so flush has nothing to cancel here
  logic unused_inputs;
  assign unused_inputs = ^{flush, ld_check_addr[1:0]};

  sb_store_align #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .addr   (retire_store_addr),
    .data   (retire_store_data),
    .funct3 (retire_store_funct3),
    .waddr  (fmt_addr),
    .wdata  (fmt_data),
    .strb   (fmt_strb)
  );

  assign sb_full    = (head[IW] != tail[IW]) && (head[IW-1:0] == tail[IW-1:0]);
  assign enq        = retire_store_valid && !sb_full;
  assign mem_wr_req = (state == REQ);
  assign sb_empty   = (count == '0) && !mem_wr_req;
  assign sb_count   = count;

  // Entry storage: written at the tail with the already-formatted store
  always_ff @(posedge clk) begin
    if (enq) begin
      entries[tail[IW-1:0]] <= '{addr: fmt_addr, data: fmt_data, strb: fmt_strb};
    end
  end

  // Queue pointers and occupancy; the head stays counted until acked
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PW'(1);
      if (deq) head <= head + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: ;
      endcase
    end
  end

  // Drain FSM next state: latch head on leaving IDLE, chain on ack when more remain
  always_comb begin
    state_next = state;
    load_out   = 1'b0;
    load_idx   = head[IW-1:0];
    deq        = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          load_out   = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (mem_wr_ack) begin
          deq = 1'b1;
          if (count > PW'(1)) begin
            load_out = 1'b1;
            load_idx = head[IW-1:0] + IW'(1);
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Drain FSM state and the write-port registers held stable during REQ
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      mem_wr_strb <= '0;
    end else begin
      state <= state_next;
      if (load_out) begin
        mem_wr_addr <= entries[load_idx].addr;
        mem_wr_data <= entries[load_idx].data;
        mem_wr_strb <= entries[load_idx].strb;
      end
    end
  end

  // Per-entry alias check, qualified by whether the slot lies inside the live window
  for (genvar i = 0; i < DEPTH; i++) begin : g_conflict
    logic [IW-1:0] offset;
    assign offset = IW'(i) - head[IW-1:0];
    assign hit[i] = ({1'b0, offset} < count) &&
                    (entries[i].addr[ADDR_WIDTH-1:2] == ld_check_addr[ADDR_WIDTH-1:2]);
  end

  assign ld_conflict = |hit;

`ifndef SYNTHESIS
  a_no_retire_when_full: assert property (
    @(posedge clk) disable iff (!rst_n) !(retire_store_valid && sb_full)
  ) else $warning("store_commit_buffer: retire store dropped while buffer full");
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_commit_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_commit_buffer
// Description : Directed self-checking bench for store_commit_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_commit_buffer;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        rv    = 1'b0;
  logic [31:0] ra    = '0;
  logic [31:0] rd    = '0;
  logic [2:0]  rf    = '0;
  logic        ack   = 1'b0;
  logic [31:0] lda   = '0;
  logic        full, empty, req, conf;
  logic [3:0]  count;
  logic [31:0] waddr, wdata;
  logic [3:0]  strb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  store_commit_buffer #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (8)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .flush               (flush),
    .retire_store_valid  (rv),
    .retire_store_addr   (ra),
    .retire_store_data   (rd),
    .retire_store_funct3 (rf),
    .sb_full             (full),
    .sb_empty            (empty),
    .sb_count            (count),
    .mem_wr_req          (req),
    .mem_wr_addr         (waddr),
    .mem_wr_data         (wdata),
    .mem_wr_strb         (strb),
    .mem_wr_ack          (ack),
    .ld_check_addr       (lda),
    .ld_conflict         (conf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    rv = 1'b1;
    ra = a;
    rd = d;
    rf = f;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ack   = 1'b0;
    lda   = 32'h0;
    step();
    step();
    checks++;
    if ({req, waddr, wdata, strb} !== 69'd0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b addr=%h data=%h strb=%b, want all zero", req, waddr, wdata, strb);
    end
    checks++;
    if ({full, empty, count, conf} !== {1'b0, 1'b1, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_status: got full=%b empty=%b count=%0d conf=%b, want 0 1 0 0", full, empty, count, conf);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_sb();
    present(32'h1003, 32'h0000_00AB, 3'b000);
    step();
    rv = 1'b0;
    checks++;
    if ({count, req} !== {4'd1, 1'b0}) begin
      errors++;
      $display("FAIL sb_n1: got count=%0d req=%b, want 1 0", count, req);
    end
    step();
    checks++;
    if ({req, waddr, strb, wdata} !== {1'b1, 32'h1000, 4'b1000, 32'hABABABAB}) begin
      errors++;
      $display("FAIL sb_n2: got req=%b addr=%h strb=%b data=%h, want 1 00001000 1000 abababab", req, waddr, strb, wdata);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    checks++;
    if ({empty, count, req} !== {1'b1, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL sb_drained: got empty=%b count=%0d req=%b, want 1 0 0", empty, count, req);
    end
  endtask

  task automatic test_back_to_back();
    present(32'h2002, 32'h0000_1234, 3'b001);
    step();
    present(32'h2004, 32'hDEADBEEF, 3'b010);
    step();
    rv = 1'b0;
    checks++;
    if ({req, count, waddr, strb, wdata} !== {1'b1, 4'd2, 32'h2000, 4'b1100, 32'h12341234}) begin
      errors++;
      $display("FAIL b2b_first: got req=%b count=%0d addr=%h strb=%b data=%h, want 1 2 00002000 1100 12341234", req, count, waddr, strb, wdata);
    end
    ack = 1'b1;
    step();
    checks++;
    if ({req, count, waddr, strb, wdata} !== {1'b1, 4'd1, 32'h2004, 4'b1111, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL b2b_second: got req=%b count=%0d addr=%h strb=%b data=%h, want 1 1 00002004 1111 deadbeef", req, count, waddr, strb, wdata);
    end
    step();
    ack = 1'b0;
    checks++;
    if ({req, count, empty} !== {1'b0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_done: got req=%b count=%0d empty=%b, want 0 0 1", req, count, empty);
    end
  endtask

  task automatic test_ack_idle();
    ack = 1'b1;
    present(32'h7000, 32'h77, 3'b010);
    step();
    rv = 1'b0;
    checks++;
    if ({count, req} !== {4'd1, 1'b0}) begin
      errors++;
      $display("FAIL ack_idle_n1: got count=%0d req=%b, want 1 0", count, req);
    end
    step();
    checks++;
    if ({req, count, waddr} !== {1'b1, 4'd1, 32'h7000}) begin
      errors++;
      $display("FAIL ack_idle_n2: got req=%b count=%0d addr=%h, want 1 1 00007000", req, count, waddr);
    end
    step();
    ack = 1'b0;
    checks++;
    if ({req, empty} !== {1'b0, 1'b1}) begin
      errors++;
      $display("FAIL ack_idle_done: got req=%b empty=%b, want 0 1", req, empty);
    end
  endtask

  task automatic test_fill();
    ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      present(32'h4000 + 32'(i * 4), 32'(i), 3'b010);
      step();
    end
    rv = 1'b0;
    checks++;
    if ({full, count, req, wdata} !== {1'b1, 4'd8, 1'b1, 32'd0}) begin
      errors++;
      $display("FAIL fill_full: got full=%b count=%0d req=%b data=%h, want 1 8 1 0", full, count, req, wdata);
    end
    present(32'h4100, 32'h99, 3'b010);
    step();
    checks++;
    if ({full, count} !== {1'b1, 4'd8}) begin
      errors++;
      $display("FAIL fill_drop: got full=%b count=%0d, want 1 8", full, count);
    end
    ack = 1'b1;
    step();
    rv = 1'b0;
    checks++;
    if ({count, req, wdata} !== {4'd7, 1'b1, 32'd1}) begin
      errors++;
      $display("FAIL fill_ack_drop: got count=%0d req=%b data=%h, want 7 1 1", count, req, wdata);
    end
    for (int i = 2; i < 8; i++) begin
      step();
      checks++;
      if ({req, waddr, wdata} !== {1'b1, 32'h4000 + 32'(i * 4), 32'(i)}) begin
        errors++;
        $display("FAIL fill_drain%0d: got req=%b addr=%h data=%h, want 1 %h %h", i, req, waddr, wdata, 32'h4000 + 32'(i * 4), 32'(i));
      end
    end
    step();
    ack = 1'b0;
    checks++;
    if ({req, empty, count} !== {1'b0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL fill_done: got req=%b empty=%b count=%0d, want 0 1 0", req, empty, count);
    end
  endtask

  task automatic test_conflict();
    present(32'h3008, 32'h5555AAAA, 3'b010);
    step();
    rv  = 1'b0;
    lda = 32'h300A;
    #1;
    checks++;
    if (conf !== 1'b1) begin
      errors++;
      $display("FAIL conflict_hit: got %b want 1", conf);
    end
    lda = 32'h300C;
    #1;
    checks++;
    if (conf !== 1'b0) begin
      errors++;
      $display("FAIL conflict_miss: got %b want 0", conf);
    end
    lda = 32'h3008;
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    checks++;
    if ({conf, empty} !== {1'b0, 1'b1}) begin
      errors++;
      $display("FAIL conflict_after_drain: got conf=%b empty=%b, want 0 1", conf, empty);
    end
  endtask

  task automatic test_flush();
    logic [31:0] exp_a [3];
    logic [31:0] exp_d [3];
    logic [3:0]  exp_s [3];
    exp_a[0] = 32'h5000; exp_d[0] = 32'h11111111; exp_s[0] = 4'b0001;
    exp_a[1] = 32'h5004; exp_d[1] = 32'h22222222; exp_s[1] = 4'b0011;
    exp_a[2] = 32'h5008; exp_d[2] = 32'h33333333; exp_s[2] = 4'b1000;
    flush = 1'b1;
    present(32'h5000, 32'h11, 3'b000);
    step();
    present(32'h5005, 32'h2222, 3'b001);
    step();
    present(32'h500B, 32'h33, 3'b000);
    step();
    rv = 1'b0;
    checks++;
    if (count !== 4'd3) begin
      errors++;
      $display("FAIL flush_count: got %0d want 3", count);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({req, waddr, strb, wdata} !== {1'b1, exp_a[i], exp_s[i], exp_d[i]}) begin
        errors++;
        $display("FAIL flush_write%0d: got req=%b addr=%h strb=%b data=%h, want 1 %h %b %h", i, req, waddr, strb, wdata, exp_a[i], exp_s[i], exp_d[i]);
      end
      ack = 1'b1;
      step();
    end
    ack   = 1'b0;
    flush = 1'b0;
    checks++;
    if ({req, empty} !== {1'b0, 1'b1}) begin
      errors++;
      $display("FAIL flush_done: got req=%b empty=%b, want 0 1", req, empty);
    end
  endtask

  task automatic test_bad_funct3();
    present(32'h6006, 32'h55, 3'b011);
    step();
    rv = 1'b0;
    step();
    checks++;
    if ({req, waddr, strb} !== {1'b1, 32'h6004, 4'b0000}) begin
      errors++;
      $display("FAIL bad_funct3: got req=%b addr=%h strb=%b, want 1 00006004 0000", req, waddr, strb);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL bad_funct3_drain: got empty=%b want 1", empty);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      present(32'h8000 + 32'(i * 4), 32'hC0 + 32'(i), 3'b010);
      step();
    end
    rv  = 1'b0;
    lda = 32'h8004;
    #1;
    checks++;
    if ({req, count, conf} !== {1'b1, 4'd4, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_pre: got req=%b count=%0d conf=%b, want 1 4 1", req, count, conf);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if ({req, count, empty, full, conf, waddr} !== {1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_mid_post: got req=%b count=%0d empty=%b full=%b conf=%b addr=%h, want 0 0 1 0 0 0", req, count, empty, full, conf, waddr);
    end
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_sb();
    test_back_to_back();
    test_ack_idle();
    test_fill();
    test_conflict();
    test_flush();
    test_bad_funct3();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
